// File: rtl/spram_dma.sv
// ============================================================================
// spram_dma
// ----------------------------------------------------------------------------
// Small DMA engine that moves bytes between two single-port RAMs sharing one
// clock. It runs in one of two modes, chosen when a transfer starts:
//   copy : reads src_base..src_base+N-1 from the source RAM and writes each
//          byte to dst_base..dst_base+N-1 in the destination RAM, one byte
//          per cycle. The read latency of one cycle adds a final LAST cycle.
//   fill : writes a constant byte to dst_base..dst_base+N-1, one per cycle.
// Addresses wrap modulo 2^ADDR_WIDTH. A transfer can be cut short by abort
// (no done pulse) or by reset.
//
// Ports
//   clock_a      in   single clock, rising edge
//   reset_a      in   synchronous reset, active high
//   start        in   begin a transfer (sampled only in IDLE)
//   fill         in   1 = fill mode, 0 = copy mode (sampled with start)
//   fill_data    in   constant for fill mode (sampled with start)
//   src_base     in   first source address (sampled with start)
//   dst_base     in   first destination address (sampled with start)
//   length       in   byte count N, 0..2^ADDR_WIDTH (sampled with start)
//   abort        in   stop the active transfer
//   busy         out  high while a transfer is active
//   done         out  one-cycle pulse on normal completion
//   src_address  out  source RAM address
//   src_enable   out  source RAM enable
//   src_wren     out  source RAM write enable, always 0
//   src_q        in   source RAM read data, one cycle after an enabled read
//   dst_address  out  destination RAM address
//   dst_data     out  destination RAM write data
//   dst_enable   out  destination RAM enable
//   dst_wren     out  destination RAM write enable
// ============================================================================
module spram_dma #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock_a,
    input  logic                  reset_a,
    input  logic                  start,
    input  logic                  fill,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] src_address,
    output logic                  src_enable,
    output logic                  src_wren,
    input  logic [DATA_WIDTH-1:0] src_q,
    output logic [ADDR_WIDTH-1:0] dst_address,
    output logic [DATA_WIDTH-1:0] dst_data,
    output logic                  dst_enable,
    output logic                  dst_wren
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    fillMode_q;
    logic [DATA_WIDTH-1:0]   fillData_q;
    logic [ADDR_WIDTH:0]     remain_q;
    logic                    busy_q;
    logic                    done_q;
    logic [ADDR_WIDTH-1:0]   srcAddr_q;
    logic                    srcEn_q;
    logic [ADDR_WIDTH-1:0]   dstAddr_q;
    logic                    dstWrite_q;

    logic [ADDR_WIDTH-1:0]   srcAddr_d;
    logic [ADDR_WIDTH-1:0]   dstAddr_d;
    logic [ADDR_WIDTH:0]     remain_d;
    logic                    lastBeat_d;

    // Next-address and countdown arithmetic shared by both modes.
    // The destination pointer only advances once a write has actually been
    // issued: in copy mode the first RUN cycle is a pure read, so dst_base
    // must still be on the bus when the first write goes out a cycle later.
    // Address adders are ADDR_WIDTH wide, so wrapping past all-ones to zero
    // happens for free.
    always_comb begin
        srcAddr_d  = srcAddr_q + 1'b1;
        dstAddr_d  = dstWrite_q ? (dstAddr_q + 1'b1) : dstAddr_q;
        remain_d   = remain_q - 1'b1;
        lastBeat_d = (remain_q == (ADDR_WIDTH+1)'(1));
    end

    // Main controller. All outputs are registered here alongside the state.
    // remain_q counts RUN cycles still to issue; it is one bit wider than an
    // address so a full 2^ADDR_WIDTH transfer can be expressed.
    // Abort is honoured only in RUN and LAST, which also makes start win
    // over abort in IDLE.
    always_ff @(posedge clock_a) begin
        if (reset_a) begin
            state_q    <= IDLE;
            fillMode_q <= 1'b0;
            fillData_q <= '0;
            remain_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            srcAddr_q  <= '0;
            srcEn_q    <= 1'b0;
            dstAddr_q  <= '0;
            dstWrite_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= RUN;
                            busy_q     <= 1'b1;
                            fillMode_q <= fill;
                            fillData_q <= fill_data;
                            remain_q   <= length;
                            srcAddr_q  <= src_base;
                            dstAddr_q  <= dst_base;
                            srcEn_q    <= ~fill;
                            dstWrite_q <= fill;
                        end
                    end
                end

                RUN: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        srcEn_q    <= 1'b0;
                        dstWrite_q <= 1'b0;
                    end else if (fillMode_q) begin
                        remain_q <= remain_d;
                        if (lastBeat_d) begin
                            state_q    <= DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            dstWrite_q <= 1'b0;
                        end else begin
                            dstAddr_q <= dstAddr_d;
                        end
                    end else begin
                        // Copy: the write for the read issued this cycle
                        // happens next cycle, so a write is always pending.
                        remain_q   <= remain_d;
                        dstWrite_q <= 1'b1;
                        dstAddr_q  <= dstAddr_d;
                        if (lastBeat_d) begin
                            state_q <= LAST;
                            srcEn_q <= 1'b0;
                        end else begin
                            srcAddr_q <= srcAddr_d;
                        end
                    end
                end

                LAST: begin
                    // The final copy write is on the bus during this cycle
                    // and lands at this edge whether or not abort is high.
                    state_q    <= abort ? IDLE : DONE;
                    done_q     <= ~abort;
                    busy_q     <= 1'b0;
                    dstWrite_q <= 1'b0;
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    srcEn_q    <= 1'b0;
                    dstWrite_q <= 1'b0;
                end
            endcase
        end
    end

    // Copy data is forwarded straight from the source RAM output so each
    // byte is written in the cycle its read data becomes valid. Outside a
    // copy write the latched fill byte is presented, which is zero after
    // reset.
    always_comb begin
        dst_data = (dstWrite_q && !fillMode_q) ? src_q : fillData_q;
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign src_address = srcAddr_q;
    assign src_enable  = srcEn_q;
    assign src_wren    = 1'b0;
    assign dst_address = dstAddr_q;
    assign dst_enable  = dstWrite_q;
    assign dst_wren    = dstWrite_q;

endmodule

// File: tb/tb_spram_dma.sv
// ============================================================================
// tb_spram_dma
// ----------------------------------------------------------------------------
// Directed self-checking bench for spram_dma. Two small synchronous RAM
// models stand in for the source and destination SPRAMs, and negedge
// monitors keep running totals of busy cycles, done pulses and enables so
// each scenario can compare before/after deltas against hand-computed
// values.
// ============================================================================
module tb_spram_dma;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clock_a;
    logic          reset_a;
    logic          start;
    logic          fill;
    logic [DW-1:0] fill_data;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;
    logic [AW:0]   length;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] src_address;
    logic          src_enable;
    logic          src_wren;
    logic [DW-1:0] src_q;
    logic [AW-1:0] dst_address;
    logic [DW-1:0] dst_data;
    logic          dst_enable;
    logic          dst_wren;

    bit [DW-1:0] srcMem [0:DEPTH-1];
    bit [DW-1:0] dstMem [0:DEPTH-1];
    int          hitCount [0:DEPTH-1];
    int          hitBefore [0:DEPTH-1];

    int busyTotal, doneTotal, srcEnTotal, dstEnTotal, badWrenTotal, srcWrenTotal;
    int busyBase, doneBase, srcEnBase, dstEnBase;
    int checks;
    int failures;
    int cycles;
    int badCount;

    spram_dma #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clock_a    (clock_a),
        .reset_a    (reset_a),
        .start      (start),
        .fill       (fill),
        .fill_data  (fill_data),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .src_address(src_address),
        .src_enable (src_enable),
        .src_wren   (src_wren),
        .src_q      (src_q),
        .dst_address(dst_address),
        .dst_data   (dst_data),
        .dst_enable (dst_enable),
        .dst_wren   (dst_wren)
    );

    // Free-running 10 ns clock.
    initial clock_a = 1'b0;
    always #5 clock_a = ~clock_a;

    // Source SPRAM model: registered read, data valid the cycle after an
    // enabled access.
    always @(posedge clock_a) begin
        if (src_enable)
            src_q <= srcMem[src_address];
    end

    // Destination SPRAM model: write on enable and wren, with a per-address
    // hit counter so full-range transfers can be checked for exactly-once.
    always @(posedge clock_a) begin
        if (dst_enable && dst_wren) begin
            dstMem[dst_address]   <= dst_data;
            hitCount[dst_address] <= hitCount[dst_address] + 1;
        end
    end

    // Activity monitors, sampled mid-cycle so each cycle counts once.
    always @(negedge clock_a) begin
        if (busy === 1'b1)                     busyTotal    <= busyTotal + 1;
        if (done === 1'b1)                     doneTotal    <= doneTotal + 1;
        if (src_enable === 1'b1)               srcEnTotal   <= srcEnTotal + 1;
        if (dst_enable === 1'b1)               dstEnTotal   <= dstEnTotal + 1;
        if (dst_wren === 1'b1 && !dst_enable)  badWrenTotal <= badWrenTotal + 1;
        if (src_wren !== 1'b0)                 srcWrenTotal <= srcWrenTotal + 1;
    end

    // Hard stop in case a wait somehow never returns.
    initial begin
        #400000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one start pulse; returns at the negedge of the first cycle
    // after the sampling edge.
    task automatic applyStimulus(input logic f, input logic [DW-1:0] fd,
                                 input logic [AW-1:0] sb, input logic [AW-1:0] db,
                                 input logic [AW:0] len);
        @(negedge clock_a);
        fill      = f;
        fill_data = fd;
        src_base  = sb;
        dst_base  = db;
        length    = len;
        start     = 1'b1;
        @(negedge clock_a);
        start     = 1'b0;
    endtask

    task automatic waitDone(input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clock_a);
            n++;
        end
        checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic snap();
        busyBase  = busyTotal;
        doneBase  = doneTotal;
        srcEnBase = srcEnTotal;
        dstEnBase = dstEnTotal;
    endtask

    // Directed scenario sequence.
    initial begin
        checks    = 0;
        failures  = 0;
        reset_a   = 1'b1;
        start     = 1'b0;
        fill      = 1'b0;
        fill_data = '0;
        src_base  = '0;
        dst_base  = '0;
        length    = '0;
        abort     = 1'b0;
        for (int i = 0; i < 4; i++) srcMem[i] = 8'h10 + 8'(i);
        for (int i = 0; i < 8; i++) srcMem[16'h40 + i] = 8'hA0 + 8'(i);

        // Reset state
        repeat (2) @(negedge clock_a);
        checkOutput("reset_ctrl", 32'({busy, done, src_enable, src_wren, dst_enable, dst_wren}), 32'd0);
        checkOutput("reset_addr", 32'({src_address, dst_address}), 32'd0);
        checkOutput("reset_data", 32'(dst_data), 32'd0);
        reset_a = 1'b0;

        // Copy 4 bytes 0x000 -> 0x200
        snap();
        applyStimulus(1'b0, 8'h00, 10'h000, 10'h200, 11'd4);
        checkOutput("copy_first_read", 32'({busy, src_enable, dst_enable}), 32'b110);
        checkOutput("copy_first_addr", 32'(src_address), 32'h000);
        waitDone("copy", cycles);
        checkOutput("copy_done_latency", 32'(cycles), 32'd5);
        checkOutput("copy_busy_at_done", 32'(busy), 32'd0);
        @(negedge clock_a);
        checkOutput("copy_done_pulse_len", 32'(done), 32'd0);
        checkOutput("copy_busy_cycles", 32'(busyTotal - busyBase), 32'd5);
        checkOutput("copy_src_reads", 32'(srcEnTotal - srcEnBase), 32'd4);
        checkOutput("copy_dst_writes", 32'(dstEnTotal - dstEnBase), 32'd4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("copy_dst_%0d", i), 32'(dstMem[10'h200 + i]), 32'h10 + i);

        // Fill 4 bytes at 0x3FE with wrap
        snap();
        applyStimulus(1'b1, 8'hFF, 10'h123, 10'h3FE, 11'd4);
        checkOutput("fill_first_ctrl", 32'({busy, src_enable, dst_enable, dst_wren}), 32'b1011);
        checkOutput("fill_first_addr", 32'(dst_address), 32'h3FE);
        checkOutput("fill_first_data", 32'(dst_data), 32'hFF);
        waitDone("fill", cycles);
        checkOutput("fill_done_latency", 32'(cycles), 32'd4);
        checkOutput("fill_busy_cycles", 32'(busyTotal - busyBase), 32'd4);
        checkOutput("fill_src_reads", 32'(srcEnTotal - srcEnBase), 32'd0);
        checkOutput("fill_dst_writes", 32'(dstEnTotal - dstEnBase), 32'd4);
        checkOutput("fill_wrap", 32'({dstMem[10'h3FE], dstMem[10'h3FF], dstMem[10'h000], dstMem[10'h001]}), 32'hFFFFFFFF);
        checkOutput("fill_neighbours", 32'({dstMem[10'h3FD], dstMem[10'h002]}), 32'h0000);

        // Zero length
        snap();
        applyStimulus(1'b0, 8'h00, 10'h005, 10'h006, 11'd0);
        checkOutput("zero_done", 32'({done, busy}), 32'b10);
        @(negedge clock_a);
        checkOutput("zero_done_pulse_len", 32'(done), 32'd0);
        checkOutput("zero_activity", 32'((busyTotal - busyBase) + (srcEnTotal - srcEnBase) + (dstEnTotal - dstEnBase)), 32'd0);

        // Abort on the 3rd RUN cycle of an 8-byte copy
        snap();
        applyStimulus(1'b0, 8'h00, 10'h040, 10'h100, 11'd8);
        @(negedge clock_a);
        @(negedge clock_a);
        abort = 1'b1;
        @(negedge clock_a);
        abort = 1'b0;
        checkOutput("abort_idle", 32'({busy, done, src_enable, dst_enable, dst_wren}), 32'd0);
        repeat (4) @(negedge clock_a);
        checkOutput("abort_no_done", 32'(doneTotal - doneBase), 32'd0);
        checkOutput("abort_src_reads", 32'(srcEnTotal - srcEnBase), 32'd3);
        checkOutput("abort_dst_writes", 32'(dstEnTotal - dstEnBase), 32'd2);
        checkOutput("abort_dst_data", 32'({dstMem[10'h100], dstMem[10'h101], dstMem[10'h102]}), 32'hA0A100);

        // Restart attempt mid-copy must be ignored
        snap();
        applyStimulus(1'b0, 8'h00, 10'h000, 10'h280, 11'd4);
        @(negedge clock_a);
        fill      = 1'b1;
        fill_data = 8'h55;
        src_base  = 10'h040;
        dst_base  = 10'h300;
        length    = 11'd2;
        start     = 1'b1;
        @(negedge clock_a);
        start     = 1'b0;
        waitDone("restart", cycles);
        checkOutput("restart_done_latency", 32'(cycles), 32'd3);
        @(negedge clock_a);
        checkOutput("restart_stays_idle", 32'({busy, done}), 32'd0);
        checkOutput("restart_dst_data", 32'({dstMem[10'h280], dstMem[10'h281], dstMem[10'h282], dstMem[10'h283]}), 32'h10111213);
        checkOutput("restart_second_ignored", 32'({dstMem[10'h300], dstMem[10'h301]}), 32'h0000);
        checkOutput("restart_dst_writes", 32'(dstEnTotal - dstEnBase), 32'd4);

        // Reset on the 2nd cycle of a 16-byte fill, then a normal copy
        snap();
        applyStimulus(1'b1, 8'h77, 10'h000, 10'h010, 11'd16);
        @(negedge clock_a);
        reset_a = 1'b1;
        @(negedge clock_a);
        reset_a = 1'b0;
        checkOutput("midreset_ctrl", 32'({busy, done, src_enable, src_wren, dst_enable, dst_wren}), 32'd0);
        checkOutput("midreset_addr", 32'({src_address, dst_address}), 32'd0);
        checkOutput("midreset_data", 32'(dst_data), 32'd0);
        repeat (4) @(negedge clock_a);
        checkOutput("midreset_no_done", 32'(doneTotal - doneBase), 32'd0);
        checkOutput("midreset_writes", 32'(dstEnTotal - dstEnBase), 32'd2);
        checkOutput("midreset_dst_data", 32'({dstMem[10'h010], dstMem[10'h011], dstMem[10'h012]}), 32'h777700);
        applyStimulus(1'b0, 8'h00, 10'h000, 10'h380, 11'd2);
        waitDone("postreset", cycles);
        checkOutput("postreset_latency", 32'(cycles), 32'd3);
        checkOutput("postreset_dst_data", 32'({dstMem[10'h380], dstMem[10'h381]}), 32'h1011);

        // Full-range fill, launched with abort also high in IDLE
        snap();
        for (int i = 0; i < DEPTH; i++) hitBefore[i] = hitCount[i];
        abort = 1'b1;
        applyStimulus(1'b1, 8'h5A, 10'h000, 10'h155, 11'd1024);
        abort = 1'b0;
        checkOutput("full_start_wins", 32'(busy), 32'd1);
        waitDone("full", cycles);
        checkOutput("full_done_latency", 32'(cycles), 32'd1024);
        checkOutput("full_busy_cycles", 32'(busyTotal - busyBase), 32'd1024);
        badCount = 0;
        for (int i = 0; i < DEPTH; i++)
            if (dstMem[i] != 8'h5A || hitCount[i] - hitBefore[i] != 1) badCount++;
        checkOutput("full_each_once", 32'(badCount), 32'd0);

        // Invariants across the whole run
        @(negedge clock_a);
        checkOutput("wren_without_enable", 32'(badWrenTotal), 32'd0);
        checkOutput("src_wren_never", 32'(srcWrenTotal), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
